// File: rtl/io_cond_pkg.sv
// io_cond_pkg
//   Shared types and default constants for the pad-input conditioner.
//   strap_state_e : boot-strap FSM states (WARMUP -> SAMPLE -> LOCKED).
//   *_D constants : default parameter values used by io_cond_bit and
//                   io_in_conditioner.
package io_cond_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    SAMPLE = 2'd1,
    LOCKED = 2'd2
  } strap_state_e;

  localparam int N_IO_D        = 48;
  localparam int SYNC_STAGES_D = 2;
  localparam int DEB_CYCLES_D  = 8;
  localparam int DEB_CNT_W_D   = 4;
  localparam int STRAP_DELAY_D = 16;
  localparam int STM_IDX_D     = 44;
  localparam int BOOTSEL_IDX_D = 45;

endpackage

// File: rtl/io_cond_bit.sv
// io_cond_bit
//   One pad pin: synchroniser chain, optional debouncer and edge registers.
//   Optional feature macro: IO_COND_EDGE_DETECT_EN (edge registers and the
//   edge_en_i port exist only when it is defined; otherwise rise_o/fall_o
//   are tied to 0).
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset, clears every flop
//   pad_i      raw asynchronous pad input
//   filt_en_i  1 = debounced, 0 = synchronise only
//   edge_en_i  edge pulses allowed (strap FSM is LOCKED)
//   io_o       conditioned pin value
//   rise_o     one-cycle pulse in the cycle io_o becomes 1
//   fall_o     one-cycle pulse in the cycle io_o becomes 0
module io_cond_bit
  import io_cond_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DEB_CYCLES  = DEB_CYCLES_D,
  parameter int DEB_CNT_W   = DEB_CNT_W_D
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  input  logic filt_en_i,
`ifdef IO_COND_EDGE_DETECT_EN
  input  logic edge_en_i,
`endif
  output logic io_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DEB_CNT_W-1:0]   cnt_q;
  logic [DEB_CNT_W-1:0]   cnt_nxt;
  logic                   io_q;
  logic                   io_nxt;

  assign sync = sync_q[SYNC_STAGES-1];
  assign io_o = io_q;

  // Synchroniser stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Debounce decision; filt_en_i acts combinationally so a drop mid-count
  // lets the output follow sync on the very next edge.
  always_comb begin
    io_nxt  = io_q;
    cnt_nxt = cnt_q;
    if (!filt_en_i) begin
      io_nxt  = sync;
      cnt_nxt = '0;
    end else if (sync == io_q) begin
      cnt_nxt = '0;
    end else if (cnt_q == DEB_LAST) begin
      io_nxt  = sync;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  // Output stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      io_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      io_q  <= io_nxt;
      cnt_q <= cnt_nxt;
    end
  end

`ifdef IO_COND_EDGE_DETECT_EN
  logic rise_q;
  logic fall_q;

  // Edge stage: registered alongside io_q so the pulse lines up with the
  // new output value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= edge_en_i & io_nxt & ~io_q;
      fall_q <= edge_en_i & ~io_nxt & io_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/io_in_conditioner.sv
// io_in_conditioner
//   Conditions the raw pad inputs for the core_v_mcu io_in_i bus: per-pin
//   synchronisation, optional debouncing, edge pulses and a one-shot latch
//   of the stm / bootsel boot straps after reset release.
//   Optional feature macro: IO_COND_EDGE_DETECT_EN (edge pulses; when
//   undefined edge_rise_o / edge_fall_o are constant 0).
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   pad_in_i         raw asynchronous pad inputs
//   filt_en_i        per-pin debounce enable
//   io_in_o          conditioned inputs
//   edge_rise_o      per-pin 0->1 pulse (only once straps are locked)
//   edge_fall_o      per-pin 1->0 pulse (only once straps are locked)
//   strap_stm_o      latched stm strap
//   strap_bootsel_o  latched bootsel strap
//   strap_valid_o    straps latched
module io_in_conditioner
  import io_cond_pkg::*;
#(
  parameter int N_IO        = N_IO_D,
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DEB_CYCLES  = DEB_CYCLES_D,
  parameter int DEB_CNT_W   = DEB_CNT_W_D,
  parameter int STRAP_DELAY = STRAP_DELAY_D,
  parameter int STM_IDX     = STM_IDX_D,
  parameter int BOOTSEL_IDX = BOOTSEL_IDX_D
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_IO-1:0] pad_in_i,
  input  logic [N_IO-1:0] filt_en_i,
  output logic [N_IO-1:0] io_in_o,
  output logic [N_IO-1:0] edge_rise_o,
  output logic [N_IO-1:0] edge_fall_o,
  output logic            strap_stm_o,
  output logic            strap_bootsel_o,
  output logic            strap_valid_o
);

  localparam int               DLY_W    = $clog2(STRAP_DELAY);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STRAP_DELAY - 1);

  strap_state_e     state_q;
  logic [DLY_W-1:0] warm_cnt_q;

`ifdef IO_COND_EDGE_DETECT_EN
  // Edges stay masked through reset-release settling.
  logic edge_en;
  assign edge_en = (state_q == LOCKED);
`endif

  for (genvar g = 0; g < N_IO; g++) begin : g_pin
    io_cond_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_CNT_W  (DEB_CNT_W)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pad_i    (pad_in_i[g]),
      .filt_en_i(filt_en_i[g]),
`ifdef IO_COND_EDGE_DETECT_EN
      .edge_en_i(edge_en),
`endif
      .io_o     (io_in_o[g]),
      .rise_o   (edge_rise_o[g]),
      .fall_o   (edge_fall_o[g])
    );
  end

  // Strap FSM: the SAMPLE cycle captures io_in_o as registered before its
  // closing edge, so a pin settling in that same cycle is not seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= WARMUP;
      warm_cnt_q      <= '0;
      strap_stm_o     <= 1'b0;
      strap_bootsel_o <= 1'b0;
      strap_valid_o   <= 1'b0;
    end else begin
      case (state_q)
        WARMUP: begin
          if (warm_cnt_q == DLY_LAST) begin
            state_q <= SAMPLE;
          end else begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          strap_stm_o     <= io_in_o[STM_IDX];
          strap_bootsel_o <= io_in_o[BOOTSEL_IDX];
          strap_valid_o   <= 1'b1;
          state_q         <= LOCKED;
        end
        LOCKED: begin
          state_q <= LOCKED;
        end
        default: begin
          state_q <= WARMUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_in_conditioner.sv
// tb_io_in_conditioner
//   Randomised plus directed stimulus against a cycle-level behavioural model
//   (pad history queue, per-pin mismatch run lengths, cycle counter since
//   reset release). Works with or without IO_COND_EDGE_DETECT_EN.
module tb_io_in_conditioner;

  localparam int N   = 48;
  localparam int SS  = 2;
  localparam int DC  = 8;
  localparam int SD  = 16;
  localparam int STM = 44;
  localparam int BS  = 45;
`ifdef IO_COND_EDGE_DETECT_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pad;
  logic [N-1:0] filt;
  logic [N-1:0] io;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         stm;
  logic         bsel;
  logic         vld;

  always #5 clk = ~clk;

  io_in_conditioner dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pad_in_i       (pad),
    .filt_en_i      (filt),
    .io_in_o        (io),
    .edge_rise_o    (rise),
    .edge_fall_o    (fall),
    .strap_stm_o    (stm),
    .strap_bootsel_o(bsel),
    .strap_valid_o  (vld)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [N-1:0] hist[$];   // pad values sampled at past edges, newest first
  logic [N-1:0] m_io, m_rise, m_fall;
  int           run[N];    // consecutive filtered cycles with sync != output
  int           cyc;       // cycle number since reset release
  logic         m_stm, m_bs, m_vld;

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    logic [N-1:0] s;
    logic [N-1:0] nio;
    bit           locked;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back('0);
      m_io = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
      cyc = 0; m_stm = 0; m_bs = 0; m_vld = 0;
      return;
    end
    s   = hist[SS-1];
    nio = m_io;
    for (int i = 0; i < N; i++) begin
      if (!filt[i]) begin
        nio[i] = s[i];
        run[i] = 0;
      end else if (s[i] == m_io[i]) begin
        run[i] = 0;
      end else begin
        run[i]++;
        if (run[i] == DC) begin
          nio[i] = s[i];
          run[i] = 0;
        end
      end
    end
    locked = (cyc >= SD + 1);
    m_rise = (EDGE_ON && locked) ? (nio & ~m_io) : '0;
    m_fall = (EDGE_ON && locked) ? (~nio & m_io) : '0;
    if (cyc == SD) begin
      m_stm = m_io[STM];
      m_bs  = m_io[BS];
      m_vld = 1'b1;
    end
    m_io = nio;
    hist.push_front(pad);
    void'(hist.pop_back());
    cyc++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("io_in", 64'(io), 64'(m_io));
    chk("rise", 64'(rise), 64'(m_rise));
    chk("fall", 64'(fall), 64'(m_fall));
    chk("stm", 64'(stm), 64'(m_stm));
    chk("bootsel", 64'(bsel), 64'(m_bs));
    chk("valid", 64'(vld), 64'(m_vld));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    pad  = '1;
    filt = '0;

    // Reset release, unfiltered, pads all high
    ticks(3);
    chk("rst_io_zero", 64'(io), 64'd0);
    chk("rst_valid_zero", 64'(vld), 64'd0);
    rst = 1'b0;
    ticks(2);
    chk("rel_io_cyc2", 64'(io), 64'd0);
    tick();
    chk("rel_io_cyc3", 64'(io), 64'(48'hFFFF_FFFF_FFFF));
    ticks(20);

    // Strap capture with everything filtered
    pad = $urandom() ^ (N'($urandom()) << 32);
    pad[STM] = 1'b1;
    pad[BS]  = 1'b0;
    filt = '1;
    do_reset(3);
    ticks(16);
    chk("strap_valid_cyc16", 64'(vld), 64'd0);
    tick();
    chk("strap_valid_cyc17", 64'(vld), 64'd1);
    chk("strap_stm_cyc17", 64'(stm), 64'd1);
    chk("strap_bs_cyc17", 64'(bsel), 64'd0);
    for (int t = 0; t < 4; t++) begin
      pad[STM] = ~pad[STM];
      ticks(14);
    end
    chk("strap_stm_frozen", 64'(stm), 64'd1);

    // Glitch reject on pin 10
    pad[10] = 1'b0;
    ticks(15);
    pad[10] = 1'b1;
    ticks(7);
    pad[10] = 1'b0;
    ticks(15);
    chk("glitch_io10", 64'(io[10]), 64'd0);
    pad[10] = 1'b1;
    ticks(9);
    chk("deb_io10_edge9", 64'(io[10]), 64'd0);
    tick();
    chk("deb_io10_edge10", 64'(io[10]), 64'd1);
    chk("deb_rise10", 64'(rise[10]), 64'(EDGE_ON));
    ticks(10);

    // Unfiltered pin 20
    filt[20] = 1'b0;
    pad[20]  = 1'b1;
    ticks(6);
    pad[20] = 1'b0;
    ticks(2);
    chk("unf_io20_edge2", 64'(io[20]), 64'd1);
    tick();
    chk("unf_io20_edge3", 64'(io[20]), 64'd0);
    chk("unf_fall20", 64'(fall[20]), 64'(EDGE_ON));
    tick();
    chk("unf_fall20_gone", 64'(fall[20]), 64'd0);

    // Filter enable dropped with the counter at 5
    filt[30] = 1'b1;
    pad[30]  = 1'b0;
    ticks(12);
    pad[30] = 1'b1;
    ticks(7);
    chk("drop_io30_before", 64'(io[30]), 64'd0);
    filt[30] = 1'b0;
    tick();
    chk("drop_io30_after", 64'(io[30]), 64'd1);
    chk("drop_rise30", 64'(rise[30]), 64'(EDGE_ON));
    ticks(3);

    // Reset while LOCKED, straps re-sampled with new pad values
    pad[STM] = 1'b0;
    pad[BS]  = 1'b1;
    do_reset(1);
    chk("rerst_valid", 64'(vld), 64'd0);
    chk("rerst_io", 64'(io), 64'd0);
    ticks(17);
    chk("rerst_valid17", 64'(vld), 64'd1);
    chk("rerst_stm", 64'(stm), 64'd0);
    chk("rerst_bs", 64'(bsel), 64'd1);

    // Random soak: sparse pad flips, occasional filter changes and resets
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) pad[i] = ~pad[i];
      end
      if ($urandom_range(0, 39) == 0) filt[$urandom_range(0, N-1)] ^= 1'b1;
      if (c == 180 || c == 377) do_reset($urandom_range(1, 3));
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
